// File: rtl/imm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imm_pkg
//  Description : Shared definitions for the LEGv8 immediate generator:
//                ImmType encodings, opcode match constants, immediate field
//                positions and a sign-extension helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package imm_pkg;

    typedef logic [2:0] immTypeT;

    // ImmType encodings
    localparam immTypeT c_immNone  = 3'd0;
    localparam immTypeT c_immB     = 3'd1;
    localparam immTypeT c_immCb    = 3'd2;
    localparam immTypeT c_immD     = 3'd3;
    localparam immTypeT c_immI     = 3'd4;
    localparam immTypeT c_immIw    = 3'd5;
    localparam immTypeT c_immFault = 3'd6;

    // B format, opcode in [31:26]
    localparam logic [5:0]  c_opB     = 6'b000101;
    localparam logic [5:0]  c_opBl    = 6'b100101;
    // CB format, opcode in [31:24]
    localparam logic [7:0]  c_opCbz   = 8'b10110100;
    localparam logic [7:0]  c_opCbnz  = 8'b10110101;
    localparam logic [7:0]  c_opBcond = 8'b01010100;
    // D format, opcode in [31:21]
    localparam logic [10:0] c_opLdur  = 11'b11111000010;
    localparam logic [10:0] c_opStur  = 11'b11111000000;
    // I format, opcode in [31:22]
    localparam logic [9:0]  c_opAddi  = 10'b1001000100;
    localparam logic [9:0]  c_opSubi  = 10'b1101000100;
    localparam logic [9:0]  c_opAndi  = 10'b1001001000;
    localparam logic [9:0]  c_opOrri  = 10'b1011001000;
    // IW format, opcode in [31:23]
    localparam logic [8:0]  c_opMovz  = 9'b110100101;
    localparam logic [8:0]  c_opMovk  = 9'b111100101;

    // Immediate field positions (lsb, width)
    localparam int c_bImmLsb  = 0;
    localparam int c_bImmW    = 26;
    localparam int c_cbImmLsb = 5;
    localparam int c_cbImmW   = 19;
    localparam int c_dImmLsb  = 12;
    localparam int c_dImmW    = 9;
    localparam int c_iImmLsb  = 10;
    localparam int c_iImmW    = 12;
    localparam int c_iwImmLsb = 5;
    localparam int c_iwImmW   = 16;
    localparam int c_iwHwLsb  = 21;
    localparam int c_iwHwW    = 2;

    // Sign-extend the low 'width' bits of val to 64 bits. Called with
    // constant widths only, so it reduces to wiring.
    function automatic logic [63:0] sext64(input logic [63:0] val, input int width);
        sext64 = 64'($signed(val << (64 - width)) >>> (64 - width));
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_format_decode.sv
`default_nettype none
// ============================================================================
//  Module      : imm_format_decode
//  Description : Purely combinational LEGv8 immediate decoder. Classifies the
//                instruction format (first match wins: B, CB, D, I, IW) and
//                produces the extended, optionally shifted immediate.
//  Ports       : Instr32 (in, 32)     instruction word
//                ImmType (out, 3)     format code (NONE..FAULT)
//                BusImm  (out, DATA_W) extended immediate
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_format_decode
    import imm_pkg::*;
#(
    parameter int DATA_W       = 64,
    parameter int SHIFT_BRANCH = 0
) (
    input  logic [31:0]       Instr32,
    output logic [2:0]        ImmType,
    output logic [DATA_W-1:0] BusImm
);

    logic [5:0]  w_op6;
    logic [7:0]  w_op8;
    logic [8:0]  w_op9;
    logic [9:0]  w_op10;
    logic [10:0] w_op11;
    logic [1:0]  w_hw;
    immTypeT     w_type;
    logic [63:0] w_imm64;

    assign w_op6  = Instr32[31:26];
    assign w_op8  = Instr32[31:24];
    assign w_op9  = Instr32[31:23];
    assign w_op10 = Instr32[31:22];
    assign w_op11 = Instr32[31:21];
    assign w_hw   = Instr32[c_iwHwLsb +: c_iwHwW];

    // Everything is built at 64 bits and truncated at the port; keeping the
    // low DATA_W bits of a 64-bit sign-extend-then-shift is identical to
    // extending to DATA_W and shifting there.
    always_comb begin
        w_type  = c_immNone;
        w_imm64 = '0;
        if (w_op6 == c_opB || w_op6 == c_opBl) begin
            w_type  = c_immB;
            w_imm64 = sext64(64'(Instr32[c_bImmLsb +: c_bImmW]), c_bImmW);
            if (SHIFT_BRANCH != 0) begin
                w_imm64 = w_imm64 << 2;
            end
        end else if (w_op8 == c_opCbz || w_op8 == c_opCbnz || w_op8 == c_opBcond) begin
            w_type  = c_immCb;
            w_imm64 = sext64(64'(Instr32[c_cbImmLsb +: c_cbImmW]), c_cbImmW);
            if (SHIFT_BRANCH != 0) begin
                w_imm64 = w_imm64 << 2;
            end
        end else if (w_op11 == c_opLdur || w_op11 == c_opStur) begin
            w_type  = c_immD;
            w_imm64 = sext64(64'(Instr32[c_dImmLsb +: c_dImmW]), c_dImmW);
        end else if (w_op10 == c_opAddi || w_op10 == c_opSubi ||
                     w_op10 == c_opAndi || w_op10 == c_opOrri) begin
            w_type  = c_immI;
            w_imm64 = 64'(Instr32[c_iImmLsb +: c_iImmW]);
        end else if (w_op9 == c_opMovz || w_op9 == c_opMovk) begin
            // hw=2/3 would place the field entirely above a 32-bit bus.
            if (DATA_W == 32 && w_hw[1]) begin
                w_type  = c_immFault;
                w_imm64 = '0;
            end else begin
                w_type  = c_immIw;
                w_imm64 = 64'(Instr32[c_iwImmLsb +: c_iwImmW]) << {w_hw, 4'b0000};
            end
        end
    end

    assign ImmType = w_type;
    assign BusImm  = w_imm64[DATA_W-1:0];

endmodule
`default_nettype wire

// File: rtl/imm_gen_stage.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen_stage
//  Description : Decode-stage immediate generator with a two-entry skid
//                buffer (main + skid) on a valid/ready handshake. One cycle
//                latency, one result per cycle, flush and reset empty both
//                entries in a single edge.
//  Ports       : CLK       (in)          clock
//                Reset_L   (in)          synchronous active-low reset
//                Flush     (in)          drop buffered and same-cycle input
//                InValid   (in)          Instr32 valid
//                InReady   (out)         can accept (skid entry empty)
//                Instr32   (in, 32)      instruction word
//                OutValid  (out)         BusImm/ImmType valid
//                OutReady  (in)          downstream accepts
//                BusImm    (out, DATA_W) extended immediate
//                ImmType   (out, 3)      format code
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int DATA_W       = 64,
    parameter int SHIFT_BRANCH = 0
) (
    input  logic              CLK,
    input  logic              Reset_L,
    input  logic              Flush,
    input  logic              InValid,
    output logic              InReady,
    input  logic [31:0]       Instr32,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] BusImm,
    output logic [2:0]        ImmType
);

    localparam logic [1:0] c_stEmpty = 2'd0;
    localparam logic [1:0] c_stOne   = 2'd1;
    localparam logic [1:0] c_stFull  = 2'd2;

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_mainImm;
    immTypeT           r_mainType;
    logic [DATA_W-1:0] r_skidImm;
    immTypeT           r_skidType;

    logic [DATA_W-1:0] w_decImm;
    immTypeT           w_decType;
    logic              w_accept;
    logic              w_emit;

    imm_format_decode #(
        .DATA_W       (DATA_W),
        .SHIFT_BRANCH (SHIFT_BRANCH)
    ) u_decode (
        .Instr32 (Instr32),
        .ImmType (w_decType),
        .BusImm  (w_decImm)
    );

    // InReady comes straight from the state register, so OutReady has no
    // combinational path to it. Gating with Reset_L keeps it low for the
    // whole reset cycle, even when reset arrives mid-stream.
    assign InReady  = Reset_L && (r_state != c_stFull);
    assign OutValid = (r_state != c_stEmpty);
    assign BusImm   = r_mainImm;
    assign ImmType  = r_mainType;

    assign w_accept = InValid && InReady && !Flush;
    assign w_emit   = OutValid && OutReady;

    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            r_state    <= c_stEmpty;
            r_mainImm  <= '0;
            r_mainType <= c_immNone;
            r_skidImm  <= '0;
            r_skidType <= c_immNone;
        end else if (Flush) begin
            r_state    <= c_stEmpty;
            r_mainImm  <= '0;
            r_mainType <= c_immNone;
        end else begin
            case (r_state)
                c_stEmpty: begin
                    if (w_accept) begin
                        r_mainImm  <= w_decImm;
                        r_mainType <= w_decType;
                        r_state    <= c_stOne;
                    end
                end
                c_stOne: begin
                    if (w_accept && w_emit) begin
                        r_mainImm  <= w_decImm;
                        r_mainType <= w_decType;
                    end else if (w_accept) begin
                        // Downstream stalled: park the newcomer behind main.
                        r_skidImm  <= w_decImm;
                        r_skidType <= w_decType;
                        r_state    <= c_stFull;
                    end else if (w_emit) begin
                        r_state    <= c_stEmpty;
                    end
                end
                c_stFull: begin
                    // No accept possible here: InReady is low.
                    if (w_emit) begin
                        r_mainImm  <= r_skidImm;
                        r_mainType <= r_skidType;
                        r_state    <= c_stOne;
                    end
                end
                default: begin
                    r_state <= c_stEmpty;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imm_gen_stage
//  Description : Self-checking bench for imm_gen_stage. Two instances share
//                stimulus: DATA_W=64/SHIFT_BRANCH=1 and DATA_W=32/
//                SHIFT_BRANCH=0. Expected results come from an arithmetic
//                reference decoder and an in-order scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_gen_stage;

    logic        CLK = 1'b0;
    logic        Reset_L;
    logic        Flush;
    logic        InValid;
    logic        OutReady;
    logic [31:0] Instr32;

    logic        inReady64, outValid64, inReady32, outValid32;
    logic [63:0] busImm64;
    logic [31:0] busImm32;
    logic [2:0]  immType64, immType32;

    always #5 CLK = ~CLK;

    imm_gen_stage #(.DATA_W(64), .SHIFT_BRANCH(1)) dut64 (
        .CLK(CLK), .Reset_L(Reset_L), .Flush(Flush), .InValid(InValid),
        .InReady(inReady64), .Instr32(Instr32), .OutValid(outValid64),
        .OutReady(OutReady), .BusImm(busImm64), .ImmType(immType64)
    );

    imm_gen_stage #(.DATA_W(32), .SHIFT_BRANCH(0)) dut32 (
        .CLK(CLK), .Reset_L(Reset_L), .Flush(Flush), .InValid(InValid),
        .InReady(inReady32), .Instr32(Instr32), .OutValid(outValid32),
        .OutReady(OutReady), .BusImm(busImm32), .ImmType(immType32)
    );

    typedef struct {
        logic [2:0]  t64;
        logic [63:0] v64;
        logic [2:0]  t32;
        logic [63:0] v32;
    } entryT;

    entryT q[$];
    bit    cleared = 1'b0;
    int    nTests  = 0;
    int    nFail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference decoder: signed field values as integers, scaled, then
    // reduced modulo 2^w.
    task automatic refDecode(input logic [31:0] ins, input int w, input int sh,
                             output logic [2:0] t, output logic [63:0] v);
        longint      s;
        logic [63:0] m;
        t = 3'd0;
        v = 64'd0;
        if (ins[31:26] == 6'b000101 || ins[31:26] == 6'b100101) begin
            t = 3'd1;
            s = longint'(ins[25:0]);
            if (s >= 64'sd33554432) s = s - 64'sd67108864;
            if (sh != 0) s = s * 4;
            v = s;
        end else if (ins[31:24] == 8'hB4 || ins[31:24] == 8'hB5 || ins[31:24] == 8'h54) begin
            t = 3'd2;
            s = longint'(ins[23:5]);
            if (s >= 64'sd262144) s = s - 64'sd524288;
            if (sh != 0) s = s * 4;
            v = s;
        end else if (ins[31:21] == 11'h7C2 || ins[31:21] == 11'h7C0) begin
            t = 3'd3;
            s = longint'(ins[20:12]);
            if (s >= 64'sd256) s = s - 64'sd512;
            v = s;
        end else if (ins[31:22] == 10'h244 || ins[31:22] == 10'h344 ||
                     ins[31:22] == 10'h248 || ins[31:22] == 10'h2C8) begin
            t = 3'd4;
            v = 64'(ins[21:10]);
        end else if (ins[31:23] == 9'h1A5 || ins[31:23] == 9'h1E5) begin
            if (w == 32 && ins[22:21] >= 2'd2) begin
                t = 3'd6;
                v = 64'd0;
            end else begin
                t = 3'd5;
                case (ins[22:21])
                    2'd0:    m = 64'd1;
                    2'd1:    m = 64'd65536;
                    2'd2:    m = 64'd4294967296;
                    default: m = 64'd281474976710656;
                endcase
                v = 64'(ins[20:5]) * m;
            end
        end
        if (w == 32) v[63:32] = 32'd0;
    endtask

    task automatic updateModel();
        bit    acc;
        bit    emit;
        entryT e;
        if (!Reset_L) begin
            q.delete();
            cleared = 1'b1;
        end else if (Flush) begin
            q.delete();
            cleared = 1'b0;
        end else begin
            acc  = InValid && (q.size() < 2);
            emit = OutReady && (q.size() > 0);
            if (emit) void'(q.pop_front());
            if (acc) begin
                refDecode(Instr32, 64, 1, e.t64, e.v64);
                refDecode(Instr32, 32, 0, e.t32, e.v32);
                q.push_back(e);
                cleared = 1'b0;
            end
        end
    endtask

    task automatic checkAll(input string ctx);
        bit expReady;
        bit expValid;
        expReady = Reset_L && (q.size() < 2);
        expValid = (q.size() > 0);
        check({ctx, ":inReady64"},  64'(inReady64),  64'(expReady));
        check({ctx, ":inReady32"},  64'(inReady32),  64'(expReady));
        check({ctx, ":outValid64"}, 64'(outValid64), 64'(expValid));
        check({ctx, ":outValid32"}, 64'(outValid32), 64'(expValid));
        if (q.size() > 0) begin
            check({ctx, ":immType64"}, 64'(immType64), 64'(q[0].t64));
            check({ctx, ":busImm64"},  busImm64,       q[0].v64);
            check({ctx, ":immType32"}, 64'(immType32), 64'(q[0].t32));
            check({ctx, ":busImm32"},  64'(busImm32),  q[0].v32);
        end else if (cleared) begin
            check({ctx, ":rstType64"}, 64'(immType64), 64'd0);
            check({ctx, ":rstImm64"},  busImm64,       64'd0);
            check({ctx, ":rstType32"}, 64'(immType32), 64'd0);
            check({ctx, ":rstImm32"},  64'(busImm32),  64'd0);
        end
    endtask

    // One clock: model follows the edge, outputs are checked on the falling edge.
    task automatic step(input string ctx);
        @(posedge CLK);
        updateModel();
        @(negedge CLK);
        checkAll(ctx);
    endtask

    function automatic logic [31:0] randInstr();
        logic [31:0] r;
        logic [31:0] res;
        r = $urandom();
        case ($urandom_range(0, 7))
            0: res = {(($urandom_range(0, 1) == 1) ? 6'b100101 : 6'b000101), r[25:0]};
            1: begin
                case ($urandom_range(0, 2))
                    0:       res = {8'b10110100, r[23:0]};
                    1:       res = {8'b10110101, r[23:0]};
                    default: res = {8'b01010100, r[23:0]};
                endcase
            end
            2: res = {(($urandom_range(0, 1) == 1) ? 11'b11111000010 : 11'b11111000000), r[20:0]};
            3: begin
                case ($urandom_range(0, 3))
                    0:       res = {10'b1001000100, r[21:0]};
                    1:       res = {10'b1101000100, r[21:0]};
                    2:       res = {10'b1001001000, r[21:0]};
                    default: res = {10'b1011001000, r[21:0]};
                endcase
            end
            4: res = {(($urandom_range(0, 1) == 1) ? 9'b111100101 : 9'b110100101), r[22:0]};
            5: res = 32'd0;
            default: res = r;
        endcase
        return res;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_L  = 1'b0;
        Flush    = 1'b0;
        InValid  = 1'b0;
        OutReady = 1'b1;
        Instr32  = 32'd0;

        // Reset
        step("rst0");
        step("rst1");
        Reset_L = 1'b1;
        #1 checkAll("relReset");

        // Directed decodes, one cycle latency with OutReady high
        InValid = 1'b1; Instr32 = 32'hF85FF000;        // LDUR imm9=0x1FF
        step("ldur");
        check("ldurValid", 64'(outValid64), 64'd1);
        check("ldurType",  64'(immType64),  64'd3);
        check("ldurImm",   busImm64,        64'hFFFF_FFFF_FFFF_FFFF);

        Instr32 = 32'h17FFFFFF;                        // B imm26 all ones
        step("b");
        check("bImmShift",   busImm64,       64'hFFFF_FFFF_FFFF_FFFC);
        check("bImmNoShift", 64'(busImm32),  64'h0000_0000_FFFF_FFFF);

        Instr32 = 32'hD2F7DDE0;                        // MOVZ hw=3 imm16=0xBEEF
        step("movz");
        check("movzType64",  64'(immType64), 64'd5);
        check("movzImm64",   busImm64,       64'hBEEF_0000_0000_0000);
        check("movzType32",  64'(immType32), 64'd6);
        check("movzImm32",   64'(busImm32),  64'd0);

        Instr32 = 32'h913FFC00;                        // ADDI imm12=0xFFF
        step("addi");
        check("addiType", 64'(immType64), 64'd4);
        check("addiImm",  busImm64,       64'h0000_0000_0000_0FFF);

        Instr32 = 32'h00000000;                        // unknown
        step("unknown");
        check("unkValid", 64'(outValid64), 64'd1);
        check("unkType",  64'(immType64),  64'd0);
        check("unkImm",   busImm64,        64'd0);

        InValid = 1'b0;
        step("drain0");

        // Back-pressure: three back-to-back ADDIs (imm 1, 2, 3)
        OutReady = 1'b0;
        InValid = 1'b1; Instr32 = 32'h91000400;
        step("bp1");
        Instr32 = 32'h91000800;
        step("bp2");
        check("bpReadyLow", 64'(inReady64), 64'd0);
        Instr32 = 32'h91000C00;
        step("bp3");
        check("bpHeadA", busImm64, 64'd1);
        OutReady = 1'b1;
        step("bpRel1");
        check("bpHeadB", busImm64, 64'd2);
        step("bpRel2");
        check("bpHeadC", busImm64, 64'd3);
        InValid = 1'b0;
        step("bpRel3");
        check("bpEmpty", 64'(outValid64), 64'd0);

        // Flush while FULL with a same-cycle input
        OutReady = 1'b0;
        InValid = 1'b1; Instr32 = 32'h91000400;
        step("fl1");
        Instr32 = 32'h91000800;
        step("fl2");
        Flush = 1'b1; Instr32 = 32'hD2800020;          // MOVZ imm16=1, must be dropped
        step("flush");
        check("flushValid", 64'(outValid64), 64'd0);
        check("flushReady", 64'(inReady64),  64'd1);
        Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
        step("postFlush1");
        step("postFlush2");

        // Reset mid-stream
        OutReady = 1'b0;
        InValid = 1'b1; Instr32 = 32'h91000400;
        step("mr1");
        Instr32 = 32'h91000800;
        Reset_L = 1'b0;
        #1 check("inReadyInReset", 64'(inReady64), 64'd0);
        step("midReset");
        check("midResetValid", 64'(outValid64), 64'd0);
        Reset_L = 1'b1; InValid = 1'b0; OutReady = 1'b1;
        #1 checkAll("midResetRel");
        step("postReset");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            Instr32  = randInstr();
            InValid  = ($urandom_range(0, 9) < 7);
            OutReady = ($urandom_range(0, 9) < 6);
            Flush    = ($urandom_range(0, 99) < 3);
            Reset_L  = ($urandom_range(0, 99) != 0);
            step("rand");
        end

        Reset_L = 1'b1; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
        step("final0");
        step("final1");
        step("final2");

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
`default_nettype wire
